// File: rtl/groovy_cmd_sched_if.sv
// Bundle of HPS request/ack levels and DDR engine job signals for groovy_cmd_sched.
// Latency: none; wires only. master = scheduler side, slave = HPS/engine side.
// Backpressure: cmd_* levels are held by the requester until the matching reset_* pulse.
// Optional: GROOVY_SCHED_STATS_EN adds the 64-bit sched_stats bus.
interface groovy_cmd_sched_if;
  logic        cmd_switchres;
  logic        cmd_audio;
  logic        cmd_blit;
  logic        cmd_blit_lz4;
  logic        lz4_AB;
  logic [31:0] lz4_size;
  logic        vram_ready;
  logic        eng_done;
  logic        eng_start;
  logic [1:0]  eng_sel;
  logic        eng_lz4_AB;
  logic [31:0] eng_lz4_size;
  logic        reset_switchres;
  logic        reset_audio;
  logic        reset_blit;
  logic        reset_blit_lz4;
  logic        busy;
  logic        timeout_err;
`ifdef GROOVY_SCHED_STATS_EN
  logic [63:0] sched_stats;

  modport master (
    input  cmd_switchres, cmd_audio, cmd_blit, cmd_blit_lz4, lz4_AB, lz4_size,
           vram_ready, eng_done,
    output eng_start, eng_sel, eng_lz4_AB, eng_lz4_size, reset_switchres, reset_audio,
           reset_blit, reset_blit_lz4, busy, timeout_err, sched_stats
  );

  modport slave (
    output cmd_switchres, cmd_audio, cmd_blit, cmd_blit_lz4, lz4_AB, lz4_size,
           vram_ready, eng_done,
    input  eng_start, eng_sel, eng_lz4_AB, eng_lz4_size, reset_switchres, reset_audio,
           reset_blit, reset_blit_lz4, busy, timeout_err, sched_stats
  );
`else
  modport master (
    input  cmd_switchres, cmd_audio, cmd_blit, cmd_blit_lz4, lz4_AB, lz4_size,
           vram_ready, eng_done,
    output eng_start, eng_sel, eng_lz4_AB, eng_lz4_size, reset_switchres, reset_audio,
           reset_blit, reset_blit_lz4, busy, timeout_err
  );

  modport slave (
    output cmd_switchres, cmd_audio, cmd_blit, cmd_blit_lz4, lz4_AB, lz4_size,
           vram_ready, eng_done,
    input  eng_start, eng_sel, eng_lz4_AB, eng_lz4_size, reset_switchres, reset_audio,
           reset_blit, reset_blit_lz4, busy, timeout_err
  );
`endif
endinterface

// File: rtl/groovy_cmd_sched.sv
// Arbitrates HPS commands (switchres/audio/blit/blit_lz4) onto the single DDR engine, one job at a time.
// Latency: request -> eng_start 1 cycle; eng_done -> reset_* ack 1 cycle; watchdog aborts after TIMEOUT_CYC WAIT cycles.
// Backpressure: requests are levels held until acked; anything arriving while busy waits for IDLE.
// Optional: define GROOVY_SCHED_STATS_EN for saturating grant/timeout counters on sched_stats.
module groovy_cmd_sched #(
  parameter int          TW          = 24,
  parameter logic [TW-1:0] TIMEOUT_CYC = TW'(5_000_000)
) (
  input  logic               clk_sys,
  input  logic               reset,
  groovy_cmd_sched_if.master bus
);

  localparam logic [1:0] SEL_SWITCHRES = 2'd0;
  localparam logic [1:0] SEL_AUDIO     = 2'd1;
  localparam logic [1:0] SEL_BLIT      = 2'd2;
  localparam logic [1:0] SEL_BLIT_LZ4  = 2'd3;

  // Last value the watchdog reaches before it gives up on the job.
  localparam logic [TW-1:0] WD_LIMIT = TIMEOUT_CYC - TW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_ACK
  } state_t;

  state_t        state;
  logic          rr_video;   // 1: video wins the next audio-vs-video tie
  logic [TW-1:0] wd;

  logic          video_ok;
  logic [1:0]    video_sel;
  logic          grant_vld;
  logic [1:0]    grant_sel;
  logic          wd_expire;

  // Pick the next job from the live request levels; only acted on in IDLE.
  always_comb begin
    video_ok  = bus.vram_ready & (bus.cmd_blit | bus.cmd_blit_lz4);
    video_sel = bus.cmd_blit_lz4 ? SEL_BLIT_LZ4 : SEL_BLIT;
    grant_vld = 1'b1;
    grant_sel = SEL_SWITCHRES;
    if (bus.cmd_switchres) begin
      grant_sel = SEL_SWITCHRES;
    end else if (bus.cmd_audio && video_ok) begin
      grant_sel = rr_video ? video_sel : SEL_AUDIO;
    end else if (bus.cmd_audio) begin
      grant_sel = SEL_AUDIO;
    end else if (video_ok) begin
      grant_sel = video_sel;
    end else begin
      grant_vld = 1'b0;
    end
  end

  // A zero TIMEOUT_CYC disables the watchdog entirely.
  assign wd_expire = (TIMEOUT_CYC != '0) && (wd == WD_LIMIT);

  // Job sequencer: grant, strobe the engine, wait for completion or abort, ack the requester.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      rr_video         <= 1'b0;
      wd               <= '0;
      bus.eng_start    <= 1'b0;
      bus.eng_sel      <= SEL_SWITCHRES;
      bus.eng_lz4_AB   <= 1'b0;
      bus.eng_lz4_size <= '0;
      bus.reset_switchres <= 1'b0;
      bus.reset_audio     <= 1'b0;
      bus.reset_blit      <= 1'b0;
      bus.reset_blit_lz4  <= 1'b0;
      bus.busy         <= 1'b0;
      bus.timeout_err  <= 1'b0;
    end else begin
      bus.eng_start       <= 1'b0;
      bus.reset_switchres <= 1'b0;
      bus.reset_audio     <= 1'b0;
      bus.reset_blit      <= 1'b0;
      bus.reset_blit_lz4  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            bus.eng_sel      <= grant_sel;
            bus.eng_lz4_AB   <= bus.lz4_AB;
            bus.eng_lz4_size <= bus.lz4_size;
            bus.eng_start    <= 1'b1;
            bus.busy         <= 1'b1;
            if (grant_sel != SEL_SWITCHRES) begin
              rr_video <= ~rr_video;
            end
            state <= S_START;
          end
        end
        S_START: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.eng_done || wd_expire) begin
            // A done on the limit cycle still counts as a clean completion.
            if (!bus.eng_done) begin
              bus.timeout_err <= 1'b1;
            end
            bus.reset_switchres <= (bus.eng_sel == SEL_SWITCHRES);
            bus.reset_audio     <= (bus.eng_sel == SEL_AUDIO);
            bus.reset_blit      <= (bus.eng_sel == SEL_BLIT);
            bus.reset_blit_lz4  <= (bus.eng_sel == SEL_BLIT_LZ4);
            state <= S_ACK;
          end else begin
            wd <= wd + TW'(1);
          end
        end
        S_ACK: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GROOVY_SCHED_STATS_EN
  logic [15:0] grants_switchres;
  logic [15:0] grants_audio;
  logic [15:0] grants_video;
  logic [15:0] timeouts;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating per-class grant counters (counted in START) and abort counter.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      grants_switchres <= '0;
      grants_audio     <= '0;
      grants_video     <= '0;
      timeouts         <= '0;
    end else begin
      if (state == S_START) begin
        case (bus.eng_sel)
          SEL_SWITCHRES: grants_switchres <= sat_inc(grants_switchres);
          SEL_AUDIO:     grants_audio     <= sat_inc(grants_audio);
          default:       grants_video     <= sat_inc(grants_video);
        endcase
      end
      if (state == S_WAIT && !bus.eng_done && wd_expire) begin
        timeouts <= sat_inc(timeouts);
      end
    end
  end

  assign bus.sched_stats = {grants_switchres, grants_audio, grants_video, timeouts};
`endif

endmodule

// File: tb/tb_groovy_cmd_sched.sv
// Self-checking bench for groovy_cmd_sched: vector table, directed corner sequences,
// then randomized traffic checked by a job-level reference model in the monitor.
module tb_groovy_cmd_sched;

  localparam int TO = 100;

  logic clk_sys = 1'b0;
  logic reset;

  always #5 clk_sys = ~clk_sys;

  groovy_cmd_sched_if bus();

  groovy_cmd_sched #(.TW(24), .TIMEOUT_CYC(24'd100)) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ack_vec();
    return {bus.reset_blit_lz4, bus.reset_blit, bus.reset_audio, bus.reset_switchres};
  endfunction

  // ---------------- reference model (job-level, event times) ----------------
  typedef struct packed {
    logic rst, sw, au, bl, lz, vr, ab, done;
    logic [31:0] sz;
  } in_t;

  in_t        last_in;
  int         cyc = 0;
  bit         job_active = 0;
  int         c0 = 0;
  int         idle_from = 0;
  bit         rr_video = 0;
  bit         err_m = 0;
  logic [1:0] hold_sel = 2'd0;
  logic       hold_ab = 1'b0;
  logic [31:0] hold_sz = 32'd0;
  bit         m_any, exp_start, ack_now, to_now;
  logic [1:0] m_sel;

  // Priority rules: switchres first, audio/video alternate, lz4 over blit, video needs vram_ready.
  function automatic void arbitrate(input in_t i, input bit rr, output bit any, output logic [1:0] sel);
    bit v_ok;
    logic [1:0] vsel;
    v_ok = i.vr && (i.bl || i.lz);
    vsel = i.lz ? 2'd3 : 2'd2;
    any  = 1'b1;
    if (i.sw) sel = 2'd0;
    else if (i.au && v_ok) sel = rr ? vsel : 2'd1;
    else if (i.au) sel = 2'd1;
    else if (v_ok) sel = vsel;
    else begin any = 1'b0; sel = 2'd0; end
  endfunction

  always @(negedge clk_sys) begin
    cyc++;
    if (reset) begin
      chk("mon_reset_outputs",
          {bus.eng_start, bus.busy, ack_vec(), bus.timeout_err, bus.eng_sel, bus.eng_lz4_AB, bus.eng_lz4_size},
          64'd0);
      job_active = 0; rr_video = 0; err_m = 0; idle_from = 0;
      hold_sel = 2'd0; hold_ab = 1'b0; hold_sz = 32'd0;
    end else begin
      arbitrate(last_in, rr_video, m_any, m_sel);
      exp_start = !job_active && (cyc >= idle_from) && !last_in.rst && m_any;
      chk("mon_eng_start", bus.eng_start, exp_start);
      if (exp_start) begin
        job_active = 1; c0 = cyc;
        hold_sel = m_sel; hold_ab = last_in.ab; hold_sz = last_in.sz;
        if (m_sel != 2'd0) rr_video = !rr_video;
      end
      // A done counts only once the job has left START; WAIT lasts at most TO cycles.
      ack_now = 0; to_now = 0;
      if (job_active && cyc > c0) begin
        if (last_in.done && (cyc - 1 >= c0 + 1) && (cyc - 1 <= c0 + TO)) ack_now = 1;
        else if (cyc == c0 + TO + 1) begin ack_now = 1; to_now = 1; end
      end
      if (to_now) err_m = 1;
      chk("mon_busy", bus.busy, job_active);
      chk("mon_ack", ack_vec(), ack_now ? (4'b1 << hold_sel) : 4'b0);
      chk("mon_timeout_err", bus.timeout_err, err_m);
      chk("mon_eng_fields", {bus.eng_sel, bus.eng_lz4_AB, bus.eng_lz4_size}, {hold_sel, hold_ab, hold_sz});
      if (ack_now) begin job_active = 0; idle_from = cyc + 2; end
    end
    last_in = '{rst: reset, sw: bus.cmd_switchres, au: bus.cmd_audio, bl: bus.cmd_blit,
                lz: bus.cmd_blit_lz4, vr: bus.vram_ready, ab: bus.lz4_AB, done: bus.eng_done,
                sz: bus.lz4_size};
  end

  // ---------------- driver helpers ----------------
  // One cycle; afterwards behave as the requester and drop any acked request.
  task automatic step();
    @(posedge clk_sys);
    #2;
    if (bus.reset_switchres) bus.cmd_switchres = 1'b0;
    if (bus.reset_audio)     bus.cmd_audio     = 1'b0;
    if (bus.reset_blit)      bus.cmd_blit      = 1'b0;
    if (bus.reset_blit_lz4)  bus.cmd_blit_lz4  = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.cmd_switchres = 1'b0; bus.cmd_audio = 1'b0; bus.cmd_blit = 1'b0; bus.cmd_blit_lz4 = 1'b0;
    bus.lz4_AB = 1'b0; bus.lz4_size = 32'd0; bus.vram_ready = 1'b0; bus.eng_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_start(input int budget, output bit got, output logic [1:0] sel);
    got = 1'b0;
    sel = 2'd0;
    for (int k = 0; k < budget && !got; k++) begin
      step();
      if (bus.eng_start) begin got = 1'b1; sel = bus.eng_sel; end
    end
  endtask

  // Engine completes `delay` cycles after eng_start; ack must be visible one cycle after done.
  task automatic finish_job(input int delay, input logic [3:0] exp_ack, input string nm);
    repeat (delay) step();
    bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    chk({nm, "_ack"}, ack_vec(), exp_ack);
  endtask

  typedef struct {
    logic sw, au, bl, lz, vr, ab;
    logic [31:0] sz;
    bit exp_grant;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t       vecs[9];
  logic [1:0] exp_order[3];
  bit         got;
  logic [1:0] sel;
  int         k;
  int         cd;
  bit         cd_on;

  initial begin
    #500_000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    //        sw    au    bl    lz    vr    ab    sz            grant sel
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 2'd2};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 2'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 2'd1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234,     1'b1, 2'd3};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 2'd1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 2'd0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 2'd3};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55,       1'b0, 2'd0};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 2'd0};

    reset = 1'b1;
    clear_inputs();
    step();
    chk("reset_state", {bus.eng_start, bus.busy, ack_vec(), bus.timeout_err, bus.eng_sel}, 64'd0);

    // Table: first grant from a fresh reset for each request pattern.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      bus.cmd_switchres = vecs[i].sw; bus.cmd_audio = vecs[i].au;
      bus.cmd_blit = vecs[i].bl; bus.cmd_blit_lz4 = vecs[i].lz;
      bus.vram_ready = vecs[i].vr; bus.lz4_AB = vecs[i].ab; bus.lz4_size = vecs[i].sz;
      wait_start(6, got, sel);
      chk($sformatf("vec%0d_grant", i), got, vecs[i].exp_grant);
      if (got) begin
        chk($sformatf("vec%0d_sel", i), sel, vecs[i].exp_sel);
        if (vecs[i].exp_sel == 2'd3)
          chk($sformatf("vec%0d_lz4", i), {bus.eng_lz4_AB, bus.eng_lz4_size}, {vecs[i].ab, vecs[i].sz});
        finish_job(10, 4'b1 << vecs[i].exp_sel, $sformatf("vec%0d", i));
      end
    end

    // Three simultaneous requests: switchres, then audio, then lz4.
    do_reset();
    exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd3;
    bus.cmd_switchres = 1'b1; bus.cmd_audio = 1'b1; bus.cmd_blit_lz4 = 1'b1; bus.vram_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wait_start(10, got, sel);
      chk("order_grant", got, 1'b1);
      chk($sformatf("order_sel%0d", j), sel, exp_order[j]);
      finish_job(10, 4'b1 << exp_order[j], "order");
    end
`ifdef GROOVY_SCHED_STATS_EN
    chk("stats_after_order", bus.sched_stats, 64'h0001_0001_0001_0000);
`endif

    // lz4 beats blit; latched lz4 fields ignore later input changes.
    do_reset();
    bus.cmd_blit = 1'b1; bus.cmd_blit_lz4 = 1'b1; bus.vram_ready = 1'b1;
    bus.lz4_size = 32'h1234; bus.lz4_AB = 1'b1;
    wait_start(10, got, sel);
    chk("lz4_first_sel", sel, 2'd3);
    bus.lz4_size = 32'h0; bus.lz4_AB = 1'b0;
    step();
    chk("lz4_fields_held", {bus.eng_lz4_AB, bus.eng_lz4_size}, {1'b1, 32'h1234});
    finish_job(5, 4'b1000, "lz4_first");
    wait_start(10, got, sel);
    chk("blit_second_sel", {got, sel}, {1'b1, 2'd2});
    finish_job(5, 4'b0100, "blit_second");

    // Video blocked by vram_ready never holds up audio; blit goes once vram is ready.
    do_reset();
    bus.cmd_blit = 1'b1; bus.cmd_audio = 1'b1; bus.vram_ready = 1'b0;
    wait_start(10, got, sel);
    chk("vram_audio_sel", {got, sel}, {1'b1, 2'd1});
    finish_job(4, 4'b0010, "vram_audio");
    wait_start(10, got, sel);
    chk("vram_blit_blocked", got, 1'b0);
    bus.vram_ready = 1'b1;
    wait_start(10, got, sel);
    chk("vram_blit_sel", {got, sel}, {1'b1, 2'd2});
    finish_job(4, 4'b0100, "vram_blit");

    // Watchdog: no done -> ack after the START cycle plus TO WAIT cycles, sticky error.
    do_reset();
    bus.cmd_audio = 1'b1;
    wait_start(10, got, sel);
    chk("to_grant", got, 1'b1);
    k = 0;
    while (k < 300 && !bus.reset_audio) begin
      step();
      k++;
    end
    chk("to_latency", k, TO + 1);
    chk("to_err_set", bus.timeout_err, 1'b1);
    step();
    chk("to_err_sticky", bus.timeout_err, 1'b1);
`ifdef GROOVY_SCHED_STATS_EN
    chk("stats_timeout", bus.sched_stats, 64'h0000_0001_0000_0001);
`endif

    // Async reset in WAIT: everything clears, no ack afterwards.
    bus.cmd_blit_lz4 = 1'b1; bus.vram_ready = 1'b1;
    wait_start(10, got, sel);
    chk("rst_mid_grant", {got, sel}, {1'b1, 2'd3});
    repeat (3) step();
    reset = 1'b1;
    #1;
    chk("rst_mid_outputs",
        {bus.eng_start, bus.busy, ack_vec(), bus.timeout_err, bus.eng_sel, bus.eng_lz4_AB, bus.eng_lz4_size},
        64'd0);
`ifdef GROOVY_SCHED_STATS_EN
    chk("rst_mid_stats", bus.sched_stats, 64'd0);
`endif
    clear_inputs();
    step();
    reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("rst_mid_quiet", {bus.eng_start, ack_vec()}, 5'd0);
    end

    // Randomized traffic, checked cycle by cycle by the monitor model.
    do_reset();
    cd = 0; cd_on = 0;
    for (int n = 0; n < 3000; n++) begin
      bus.eng_done = 1'b0;
      if (cd_on) begin
        if (cd == 0) begin bus.eng_done = 1'b1; cd_on = 0; end
        else cd--;
      end else if ($urandom_range(0, 49) == 0) begin
        bus.eng_done = 1'b1;
      end
      if (!bus.cmd_switchres && $urandom_range(0, 15) == 0) bus.cmd_switchres = 1'b1;
      if (!bus.cmd_audio     && $urandom_range(0, 7) == 0)  bus.cmd_audio = 1'b1;
      if (!bus.cmd_blit      && $urandom_range(0, 7) == 0)  bus.cmd_blit = 1'b1;
      if (!bus.cmd_blit_lz4  && $urandom_range(0, 7) == 0)  bus.cmd_blit_lz4 = 1'b1;
      if ($urandom_range(0, 9) == 0) bus.vram_ready = ~bus.vram_ready;
      bus.lz4_AB   = 1'($urandom);
      bus.lz4_size = $urandom;
      step();
      if (bus.eng_start) begin
        cd_on = 1;
        cd = ($urandom_range(0, 19) == 0) ? 200 : int'($urandom_range(0, 30));
      end
      if (ack_vec() != 4'd0) cd_on = 0;
    end

    clear_inputs();
    repeat (250) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
